// File: rtl/regfile_sb.sv
// Two-read / two-write register file with a per-entry scoreboard (busy bit) that
// tracks registers whose producer has issued but not yet written back.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_nxt;

    logic              wr0_ok;
    logic              wr1_ok;
    logic              iss_ok;

    logic [ADDR_W-1:0] ra_v   [2];
    logic [DATA_W-1:0] rd_v   [2];
    logic              busy_v [2];

    // Port 1 wins a same-address collision, so port 0 simply stands down.
    assign wr1_ok = we1 && (wa1 != '0);
    assign wr0_ok = we0 && (wa0 != '0) && !(wr1_ok && (wa1 == wa0));
    assign iss_ok = iss_en && (iss_rd != '0);

    assign ra_v[0] = ra1;
    assign ra_v[1] = ra2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic hit0;
            logic hit1;
            hit0 = (BYPASS != 0) && (ra_v[p] != '0) && we0 && (wa0 == ra_v[p]);
            hit1 = (BYPASS != 0) && (ra_v[p] != '0) && we1 && (wa1 == ra_v[p]);
            rd_v[p]   = mem[ra_v[p]];
            busy_v[p] = busy[ra_v[p]] && (ra_v[p] != '0);
            if (hit1) begin
                rd_v[p] = wd1;
            end else if (hit0) begin
                rd_v[p] = wd0;
            end
            if (hit0 || hit1) begin
                busy_v[p] = 1'b0;
            end
            // Reset forces quiet outputs even though forwarding would still see inputs.
            if (rst) begin
                rd_v[p]   = '0;
                busy_v[p] = 1'b0;
            end
        end
    end

    assign rd1      = rd_v[0];
    assign rd2      = rd_v[1];
    assign busy1    = busy_v[0];
    assign busy2    = busy_v[1];
    assign stall    = busy_v[0] | busy_v[1];
    assign pend_cnt = cnt_q;

    // Issue is applied last so a same-cycle issue and write leaves the entry busy.
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) begin
            busy_nxt[wa0] = 1'b0;
        end
        if (wr1_ok) begin
            busy_nxt[wa1] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
            if (wr1_ok) begin
                mem[wa1] <= wd1;
            end
            if (wr0_ok) begin
                mem[wa0] <= wd0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one forwarding instance and one non-forwarding
// instance share stimulus; expectations are queued and retired in order.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa0, wa1, iss_rd;
    logic [31:0] wd0, wd1;
    logic        we0, we1, iss_en;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy1_a, busy2_a, stall_a, busy1_b, busy2_b, stall_b;
    logic [5:0]  cnt_a, cnt_b;

    int          n_cmp;
    int          n_err;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy1(busy1_a), .busy2(busy2_a),
        .stall(stall_a), .pend_cnt(cnt_a)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy1(busy1_b), .busy2(busy2_b),
        .stall(stall_b), .pend_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_underflow: observed %h with no expectation queued", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        ra1 = '0; ra2 = '0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_en = 1'b0; iss_rd = '0;

        // Reset state
        #2;
        expect_val("rst_rd1", 32'h0);
        expect_val("rst_cnt", 32'h0);
        expect_val("rst_stall", 32'h0);
        check(rd1_a);
        check(32'(cnt_a));
        check(32'(stall_a));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Write r5 through port 0, forwarded vs stored
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5;
        expect_val("byp_rd1_r5_same", 32'hDEADBEEF);
        expect_val("nb_rd1_r5_same", 32'h0);
        #1; check(rd1_a); check(rd1_b);
        tick();
        we0 = 1'b0;
        expect_val("byp_rd1_r5_next", 32'hDEADBEEF);
        expect_val("nb_rd1_r5_next", 32'hDEADBEEF);
        #1; check(rd1_a); check(rd1_b);

        // Writes to r0 are dropped
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra2 = 5'd0;
        expect_val("byp_rd2_r0_same", 32'h0);
        #1; check(rd2_a);
        tick();
        we0 = 1'b0;
        expect_val("byp_rd2_r0_next", 32'h0);
        expect_val("nb_rd2_r0_next", 32'h0);
        #1; check(rd2_a); check(rd2_b);

        // Dual write collision on r7
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra2 = 5'd7;
        expect_val("byp_rd2_r7_same", 32'h22);
        #1; check(rd2_a);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        expect_val("byp_rd2_r7_next", 32'h22);
        expect_val("nb_rd2_r7_next", 32'h22);
        #1; check(rd2_a); check(rd2_b);

        // Issue r3, then resolve it by a write
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        iss_en = 1'b0; ra1 = 5'd3;
        expect_val("busy1_r3", 32'h1);
        expect_val("stall_r3", 32'h1);
        expect_val("cnt_r3", 32'h1);
        #1; check(32'(busy1_a)); check(32'(stall_a)); check(32'(cnt_a));
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
        expect_val("byp_busy1_fwd", 32'h0);
        expect_val("byp_stall_fwd", 32'h0);
        expect_val("nb_busy1_fwd", 32'h1);
        expect_val("cnt_before_wb_edge", 32'h1);
        #1; check(32'(busy1_a)); check(32'(stall_a)); check(32'(busy1_b)); check(32'(cnt_a));
        tick();
        we0 = 1'b0;
        expect_val("cnt_after_wb", 32'h0);
        expect_val("busy1_after_wb", 32'h0);
        expect_val("rd1_r3_wb", 32'h55);
        #1; check(32'(cnt_a)); check(32'(busy1_a)); check(rd1_a);

        // Re-issue of an already busy register
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        expect_val("cnt_first_iss", 32'h1);
        #1; check(32'(cnt_a));
        tick();
        iss_en = 1'b0;
        expect_val("cnt_reissue", 32'h1);
        expect_val("busy1_reissue", 32'h1);
        #1; check(32'(cnt_a)); check(32'(busy1_a));
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h66;
        tick();
        we1 = 1'b0;
        expect_val("cnt_clear_p1", 32'h0);
        #1; check(32'(cnt_a));

        // Same-cycle issue and write to r9: new producer wins
        iss_en = 1'b1; iss_rd = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; ra2 = 5'd9;
        tick();
        iss_en = 1'b0; we0 = 1'b0;
        expect_val("busy2_r9", 32'h1);
        expect_val("cnt_r9", 32'h1);
        expect_val("rd2_r9", 32'h99);
        expect_val("nb_cnt_r9", 32'h1);
        #1; check(32'(busy2_a)); check(32'(cnt_a)); check(rd2_a); check(32'(cnt_b));
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9A;
        tick();
        we0 = 1'b0;
        expect_val("cnt_r9_clear", 32'h0);
        #1; check(32'(cnt_a));

        // Issue to r0 is ignored
        iss_en = 1'b1; iss_rd = 5'd0;
        tick();
        iss_en = 1'b0;
        expect_val("cnt_iss_r0", 32'h0);
        #1; check(32'(cnt_a));

        // Fill the scoreboard
        iss_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            iss_rd = 5'(i);
            tick();
        end
        iss_en = 1'b0; ra1 = 5'd5;
        expect_val("cnt_full", 32'd31);
        expect_val("nb_cnt_full", 32'd31);
        expect_val("busy1_full", 32'h1);
        expect_val("stall_full", 32'h1);
        #1; check(32'(cnt_a)); check(32'(cnt_b)); check(32'(busy1_a)); check(32'(stall_a));

        // Asynchronous reset pulse between edges with a write pending
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77; ra2 = 5'd12;
        #1; rst = 1'b1;
        expect_val("arst_cnt", 32'h0);
        expect_val("arst_rd1", 32'h0);
        expect_val("arst_rd2_masked", 32'h0);
        expect_val("arst_stall", 32'h0);
        expect_val("arst_busy1", 32'h0);
        #1; check(32'(cnt_a)); check(rd1_a); check(rd2_a); check(32'(stall_a)); check(32'(busy1_a));
        tick();
        we0 = 1'b0;
        #1; rst = 1'b0;
        expect_val("post_rst_nb_rd2", 32'h0);
        expect_val("post_rst_rd2", 32'h0);
        expect_val("post_rst_cnt", 32'h0);
        #1; check(rd2_b); check(rd2_a); check(32'(cnt_a));
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77;
        tick();
        we0 = 1'b0;
        expect_val("first_edge_rd2", 32'h77);
        expect_val("first_edge_nb_rd2", 32'h77);
        expect_val("post_rst_r5", 32'h0);
        #1; check(rd2_a); check(rd2_b); check(rd1_a);

        // No forwarding in the BYPASS=0 build
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hA5; ra1 = 5'd4;
        expect_val("nb_rd1_r4_same", 32'h0);
        expect_val("byp_rd1_r4_same", 32'hA5);
        #1; check(rd1_b); check(rd1_a);
        tick();
        we0 = 1'b0;
        expect_val("nb_rd1_r4_next", 32'hA5);
        #1; check(rd1_b);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
